// File: rtl/serial_pkg.sv
// Shared definitions for the framed serial transmitter/receiver pair.
// Holds the FSM encoding, line levels and a constant-width helper.
package serial_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   localparam logic LINE_IDLE  = 1'b1;
   localparam logic LINE_START = 1'b0;

   // Smallest r with 2**r >= v; usable in parameter context.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period divider: TICK marks the last CLK of each DIV-cycle bit while EN is high.
// Zero latency from EN; no backpressure, counter is held at 0 while EN is low.
module bit_tick_gen
   import serial_pkg::*;
#(
   parameter int DIV = 4
) (
   input  logic CLK,
   input  logic RST,
   input  logic EN,
   output logic TICK
);

   localparam int CW = (DIV > 1) ? clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   assign TICK = EN && (cnt == LAST);

   always_ff @(posedge CLK) begin
      if (RST || !EN || TICK) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/nibble_serial_tx.sv
// Framed parallel-to-serial transmitter: start, LSB-first data, optional even parity, stop.
// Frame occupies DIV*(2+DATA_W+PARITY_EN) cycles after the load; loads are refused (READY low) until DONE.
module nibble_serial_tx
   import serial_pkg::*;
#(
   parameter int DATA_W    = 4,
   parameter int DIV       = 4,
   parameter bit PARITY_EN = 1'b1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [DATA_W-1:0] D,
   input  logic              LOAD,
   output logic              READY,
   output logic              TXD,
   output logic              BUSY,
   output logic              DONE
);

   localparam int BW = clog2(DATA_W) + 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

   state_t            state, state_nxt;
   logic [DATA_W-1:0] sr, sr_nxt;
   logic [BW-1:0]     bit_cnt, bit_nxt;
   logic              par, par_nxt;
   logic              txd_nxt;
   logic              done_nxt;
   logic              tick;

   bit_tick_gen #(.DIV(DIV)) u_tick (
      .CLK  (CLK),
      .RST  (RST),
      .EN   (state != IDLE),
      .TICK (tick)
   );

   assign READY = (state == IDLE);
   assign BUSY  = ~READY;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         sr      <= '0;
         bit_cnt <= '0;
         par     <= 1'b0;
         TXD     <= LINE_IDLE;
         DONE    <= 1'b0;
      end else begin
         state   <= state_nxt;
         sr      <= sr_nxt;
         bit_cnt <= bit_nxt;
         par     <= par_nxt;
         TXD     <= txd_nxt;
         DONE    <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      sr_nxt    = sr;
      bit_nxt   = bit_cnt;
      par_nxt   = par;
      done_nxt  = 1'b0;
      txd_nxt   = LINE_IDLE;

      case (state)
         IDLE: begin
            if (LOAD) begin
               state_nxt = START;
               sr_nxt    = D;
               par_nxt   = ^D;
               bit_nxt   = '0;
            end
         end
         START: begin
            if (tick) state_nxt = DATA;
         end
         DATA: begin
            if (tick) begin
               sr_nxt = sr >> 1;
               if (bit_cnt == LAST_BIT) begin
                  bit_nxt   = '0;
                  state_nxt = PARITY_EN ? PARITY : STOP;
               end else begin
                  bit_nxt = bit_cnt + 1'b1;
               end
            end
         end
         PARITY: begin
            if (tick) state_nxt = STOP;
         end
         STOP: begin
            if (tick) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Line level is registered from the state being entered so TXD aligns with the state.
      case (state_nxt)
         START:   txd_nxt = LINE_START;
         DATA:    txd_nxt = sr_nxt[0];
         PARITY:  txd_nxt = par;
         default: txd_nxt = LINE_IDLE;
      endcase
   end

endmodule

// File: tb/tb_nibble_serial_tx.sv
// Directed bench for nibble_serial_tx: default build, DIV=1/no-parity build, 8-bit build.
module tb_nibble_serial_tx;

   logic       CLK;
   logic       rst;
   logic [3:0] d_a, d_b;
   logic [7:0] d_c;
   logic       load_a, load_b, load_c;
   logic       ready_a, txd_a, busy_a, done_a;
   logic       ready_b, txd_b, busy_b, done_b;
   logic       ready_c, txd_c, busy_c, done_c;

   int vectors = 0;
   int errs    = 0;

   nibble_serial_tx #(.DATA_W(4), .DIV(4), .PARITY_EN(1'b1)) dut_a (
      .CLK(CLK), .RST(rst), .D(d_a), .LOAD(load_a),
      .READY(ready_a), .TXD(txd_a), .BUSY(busy_a), .DONE(done_a)
   );

   nibble_serial_tx #(.DATA_W(4), .DIV(1), .PARITY_EN(1'b0)) dut_b (
      .CLK(CLK), .RST(rst), .D(d_b), .LOAD(load_b),
      .READY(ready_b), .TXD(txd_b), .BUSY(busy_b), .DONE(done_b)
   );

   nibble_serial_tx #(.DATA_W(8), .DIV(2), .PARITY_EN(1'b1)) dut_c (
      .CLK(CLK), .RST(rst), .D(d_c), .LOAD(load_c),
      .READY(ready_c), .TXD(txd_c), .BUSY(busy_c), .DONE(done_c)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Observed vector per DUT: {TXD, READY, BUSY, DONE}
   function automatic logic [3:0] obs(input int w);
      case (w)
         0:       return {txd_a, ready_a, busy_a, done_a};
         1:       return {txd_b, ready_b, busy_b, done_b};
         default: return {txd_c, ready_c, busy_c, done_c};
      endcase
   endfunction

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
      vectors++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s: observed %b expected %b", tag, got, exp);
      end
   endtask

   // Caller has set D/LOAD in cycle 0. seq[i] is the hand-computed line level of bit period i.
   task automatic frame(input int which, input string tag, input logic [15:0] seq,
                        input int nbits, input int div, input int ign,
                        input bit reload, input logic [7:0] rd);
      int f;
      f = nbits * div;
      for (int c = 1; c <= f; c++) begin
         step();
         load_a = 1'b0; load_b = 1'b0; load_c = 1'b0;
         if (c == ign) begin
            load_a = 1'b1;
            d_a    = 4'h0;
         end
         chk($sformatf("%s c%0d", tag, c), obs(which), {seq[(c-1)/div], 3'b010});
      end
      step();
      load_a = 1'b0; load_b = 1'b0; load_c = 1'b0;
      chk($sformatf("%s done c%0d", tag, f + 1), obs(which), 4'b1101);
      if (reload) begin
         case (which)
            0:       begin d_a = rd[3:0]; load_a = 1'b1; end
            1:       begin d_b = rd[3:0]; load_b = 1'b1; end
            default: begin d_c = rd;      load_c = 1'b1; end
         endcase
      end else begin
         step();
         chk($sformatf("%s idle c%0d", tag, f + 2), obs(which), 4'b1100);
      end
   endtask

   initial begin
      rst = 1'b1;
      d_a = 4'hF; d_b = 4'h0; d_c = 8'h00;
      load_a = 1'b1; load_b = 1'b0; load_c = 1'b0;

      // Reset held 3 cycles with LOAD asserted: nothing may be captured.
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("reset r%0d", i), obs(0), 4'b1100);
      end
      rst = 1'b0;
      load_a = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("post_reset i%0d", i), obs(0), 4'b1100);
      end
      chk("reset dut_b", obs(1), 4'b1100);
      chk("reset dut_c", obs(2), 4'b1100);

      // 4'b1011: start 0, data 1,1,0,1, parity 1, stop 1
      d_a = 4'b1011; load_a = 1'b1;
      frame(0, "basic", 16'b1110110, 7, 4, -1, 1'b0, 8'h00);

      // Same frame with a LOAD of 4'h0 during cycle 10
      d_a = 4'b1011; load_a = 1'b1;
      frame(0, "ignored", 16'b1110110, 7, 4, 10, 1'b0, 8'h00);

      // 4'h5 then 4'hA loaded in the DONE cycle
      d_a = 4'h5; load_a = 1'b1;
      frame(0, "b2b_5", 16'b1001010, 7, 4, -1, 1'b1, 8'h0A);
      frame(0, "b2b_A", 16'b1010100, 7, 4, -1, 1'b0, 8'h00);

      // Reset asserted in cycle 14 of a 4'h5 frame
      d_a = 4'h5; load_a = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         step();
         load_a = 1'b0;
         if (c == 13) chk("midrst c13", obs(0), 4'b1010);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst c15", obs(0), 4'b1100);
      for (int c = 16; c <= 32; c++) begin
         step();
         chk($sformatf("midrst idle c%0d", c), obs(0), 4'b1100);
      end
      // 4'h3: data 1,1,0,0, parity 0
      d_a = 4'h3; load_a = 1'b1;
      frame(0, "after_rst", 16'b1000110, 7, 4, -1, 1'b0, 8'h00);

      // DIV=1, no parity, 4'b0110: 0,0,1,1,0,1 then DONE in cycle 7
      d_b = 4'b0110; load_b = 1'b1;
      frame(1, "div1", 16'b101100, 6, 1, -1, 1'b0, 8'h00);

      // DATA_W=8, 8'hA5: data 1,0,1,0,0,1,0,1, parity 0
      d_c = 8'hA5; load_c = 1'b1;
      frame(2, "w8", 16'b10101001010, 11, 2, -1, 1'b0, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule

// File: doc/nibble_serial_tx.md
Name: nibble_serial_tx

Overview:
- Parallel-in, serial-out framed transmitter. It accepts a DATA_W-bit word on a load handshake and shifts it out on one line as start, data (LSB first), optional even parity, then stop.
- It is the sending end for the team's parallel capture registers: it turns a captured word back into a timed bit stream for a downstream serial receiver.
- Bit period is a fixed number of CLK cycles, set by a parameter.

Parameters:
- DATA_W, 4, payload width in bits (1..16).
- DIV, 4, CLK cycles per serial bit (>=1).
- PARITY_EN, 1, 1 = append an even-parity bit after the data; 0 = no parity bit.

Ports:
- CLK  input  1  single system clock; all state changes on its rising edge.
- RST  input  1  synchronous, active-high reset.
- D  input  DATA_W  parallel word to send; sampled only on an accepted load.
- LOAD  input  1  load request; accepted when LOAD && READY at a rising edge.
- READY  output  1  high when idle and able to accept a load.
- TXD  output  1  serial line; idles high.
- BUSY  output  1  high while a frame is in progress (inverse of READY).
- DONE  output  1  one-cycle pulse after the stop bit completes.

Behaviour:
- Reset: RST high at a rising edge forces the following, regardless of state:
  - state = IDLE, TXD = 1, READY = 1, BUSY = 0, DONE = 0.
  - shift register, bit counter and divider counter = 0.
- Reset mid-frame aborts the frame with no DONE pulse. TXD is 1 from the next edge.
- States: IDLE, START, DATA, PARITY, STOP. Transitions:
  - IDLE -> START on an accepted load.
  - START -> DATA after DIV cycles.
  - DATA -> PARITY after DATA_W bit periods if PARITY_EN = 1, otherwise DATA -> STOP.
  - PARITY -> STOP after DIV cycles.
  - STOP -> IDLE after DIV cycles.
- Load: at the accepting edge (cycle 0), D is copied into the shift register, parity is computed as the XOR of all D bits, and state becomes START. READY drops in cycle 1.
- LOAD while READY = 0 is ignored. There is no queue, and D changes during a frame have no effect.
- Divider counter:
  - Counts 0..DIV-1 within each bit.
  - On the terminal count it advances the bit counter or the state, and shifts the register right by one in DATA.
  - With DIV = 1 each bit lasts exactly one cycle.
- TXD is registered (no combinational path from D or LOAD):
  - START: 0.
  - DATA: shift-register bit 0.
  - PARITY: stored even-parity bit.
  - STOP and IDLE: 1.
- Timing from the load edge at cycle 0:
  - Start bit in cycles 1..DIV.
  - Data bit k in cycles DIV*(1+k)+1 .. DIV*(2+k).
  - Frame length F = DIV*(2+DATA_W+PARITY_EN) cycles (cycles 1..F).
- Frame end:
  - Cycle F+1: DONE = 1, READY = 1, BUSY = 0, TXD = 1.
  - DONE is low in every other cycle.
- Back-to-back: a load accepted in cycle F+1 starts the next start bit in cycle F+2, giving exactly one idle-high cycle between frames.
- LOAD and RST high together: RST wins and nothing is captured.
- Bit counter width is clog2(DATA_W)+1. It wraps to 0 on leaving DATA.

Decomposition:
- Shared package (serial_pkg) holds:
  - state encoding localparams IDLE=0, START=1, DATA=2, PARITY=3, STOP=4 (3 bits);
  - line-level constants LINE_IDLE=1, LINE_START=0;
  - a clog2 function.
- Sub-module bit_tick_gen (parameter DIV, ports CLK, RST, EN, TICK):
  - divider counter that produces TICK on the last cycle of each bit period;
  - cleared while EN = 0.
  - The same generator will be reused by the matching serial receiver.

Test Plan:
- Reset: hold RST for 3 cycles with LOAD = 1 and D = 4'hF -> TXD = 1, READY = 1, BUSY = 0, DONE = 0 throughout; nothing is transmitted after release.
- Basic frame (DIV=4, PARITY_EN=1): D = 4'b1011, LOAD pulsed at cycle 0 ->
  - TXD = 0 in cycles 1-4, 1 in 5-8, 1 in 9-12, 0 in 13-16, 1 in 17-20;
  - parity 1 in 21-24; stop 1 in 25-28;
  - DONE = 1 and READY = 1 only in cycle 29.
- Ignored load: pulse LOAD with D = 4'h0 at cycle 10 of the frame above -> the serial bit sequence is unchanged, and exactly one DONE occurs.
- Back-to-back: load 4'h5, then load 4'hA in the DONE cycle ->
  - second start bit begins exactly 1 cycle later;
  - frame 2 data = 0,1,0,1 (LSB first) with parity 0.
- Reset mid-frame: assert RST at cycle 14 -> TXD = 1 from cycle 15, READY = 1, no DONE pulse; a new load of 4'h3 afterwards produces a correct full frame.
- Parameter variants:
  - DIV=1, PARITY_EN=0, D = 4'b0110 -> TXD = 0,0,1,1,0,1 over cycles 1-6, DONE in cycle 7.
  - DATA_W=8, D = 8'hA5 -> LSB-first bits 1,0,1,0,0,1,0,1, parity 0.
